uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART serial-to-parallel receiver. It enables and resynchronises the receiver, and validates each captured frame for start, parity, stop and break. Validated frames are buffered in a small FIFO with per-entry error status. The host drains the FIFO through a valid/ready handshake. The block sits between the receiver (frame_in, frame_valid, rx_active) and the host/register interface, all in the baud_clk domain.

---
 rtl/uart_rx_ctrl.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: enables/resyncs the receiver, validates captured
// frames (start/parity/stop/break) and queues them with error status for the host.
module uart_rx_ctrl #(
  parameter  int DATA_BITS  = 8,
  parameter  int PARITY_EN  = 1,
  parameter  int PARITY_ODD = 0,
  parameter  int STOP_BITS  = 1,
  parameter  int FIFO_DEPTH = 4,
  parameter  int TIMEOUT    = 15,
  localparam int FRAME_W    = 1 + DATA_BITS + PARITY_EN + STOP_BITS,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 baud_clk,
  input  logic                 reset_n,
  input  logic                 rx_enable,
  input  logic [FRAME_W-1:0]   frame_in,
  input  logic                 frame_valid,
  input  logic                 rx_active,
  output logic                 sipo_rst_n,
  output logic [DATA_BITS-1:0] host_data,
  output logic [2:0]           host_err,
  output logic                 host_valid,
  input  logic                 host_ready,
  output logic [CW-1:0]        fifo_count,
  output logic                 overrun,
  input  logic                 clr_overrun,
  output logic                 timeout_pulse
);

  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam int PAR_IDX = DATA_BITS + 1;

  typedef enum logic [1:0] {S_OFF, S_ARMED, S_CHECK, S_RESYNC} state_e;

  typedef struct packed {
    logic                 brk;
    logic                 framing;
    logic                 parity;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  state_e               state_q, state_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        cnt_inc;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 sipo_rst_n_q, sipo_rst_n_d;
  logic                 timeout_pulse_q, timeout_pulse_d;
  logic                 push;
  entry_t               chk_entry;

  entry_t               mem_q [FIFO_DEPTH];
  entry_t               mem_d [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overrun_q, overrun_d;
  entry_t               head_q, head_d;
  logic                 host_valid_q, host_valid_d;
  logic                 pop, full, push_ok, drop;

  // ---------------------------------------------------------------- control FSM
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_OFF;
      cnt_q           <= '0;
      frame_q         <= '0;
      sipo_rst_n_q    <= 1'b0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      frame_q         <= frame_d;
      sipo_rst_n_q    <= sipo_rst_n_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    frame_d = frame_q;
    push    = 1'b0;
    case (state_q)
      S_OFF: begin
        if (rx_enable) state_d = S_ARMED;
      end
      S_ARMED: begin
        // Disable wins over everything, including a frame arriving this cycle.
        if (!rx_enable) begin
          state_d = S_OFF;
        end else if (frame_valid) begin
          frame_d = frame_in;
          state_d = S_CHECK;
        end else if (rx_active) begin
          cnt_d = cnt_inc;
          if (cnt_inc == TW'(TIMEOUT)) begin
            cnt_d   = '0;
            state_d = S_RESYNC;
          end
        end
      end
      S_CHECK: begin
        push    = 1'b1;
        state_d = rx_enable ? S_ARMED : S_OFF;
      end
      S_RESYNC: begin
        state_d = S_ARMED;
      end
      default: state_d = S_OFF;
    endcase
    // Receiver reset and resync pulse are registered off the next state so they
    // stay glitch-free while tracking the FSM cycle-for-cycle.
    sipo_rst_n_d    = (state_d == S_ARMED) || (state_d == S_CHECK);
    timeout_pulse_d = (state_d == S_RESYNC);
  end

  // ---------------------------------------------------------------- frame check
  always_comb begin
    chk_entry         = '0;
    chk_entry.data    = frame_q[DATA_BITS:1];
    chk_entry.brk     = ~|frame_q;
    chk_entry.parity  = (PARITY_EN != 0) &&
                        ((^frame_q[DATA_BITS:1] ^ frame_q[PAR_IDX]) != (PARITY_ODD != 0));
    chk_entry.framing = frame_q[0] | ~&frame_q[FRAME_W-1 -: STOP_BITS] | chk_entry.brk;
  end

  // ---------------------------------------------------------------- RX FIFO
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q        <= '{default: '0};
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      overrun_q    <= 1'b0;
      head_q       <= '0;
      host_valid_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
      head_q       <= head_d;
      host_valid_q <= host_valid_d;
    end
  end

  always_comb begin
    pop     = host_valid_q & host_ready;
    full    = (count_q == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push_ok = push & (~full | pop);
    drop    = push & full & ~pop;

    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = chk_entry;

    wr_ptr_d  = wr_ptr_q + PW'(push_ok);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q + CW'(push_ok) - CW'(pop);
    overrun_d = drop | (overrun_q & ~clr_overrun);

    // Head is registered from the post-edge view so it is valid with host_valid.
    host_valid_d = (count_d != '0);
    head_d       = host_valid_d ? mem_d[rd_ptr_d] : '0;
  end

  assign sipo_rst_n    = sipo_rst_n_q;
  assign timeout_pulse = timeout_pulse_q;
  assign host_data     = head_q.data;
  assign host_err      = {head_q.brk, head_q.framing, head_q.parity};
  assign host_valid    = host_valid_q;
  assign fifo_count    = count_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed + randomized bench for uart_rx_ctrl; expected FIFO contents come from a
// queue model that decodes frames arithmetically.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;
  localparam int FW    = 11;

  logic          baud_clk = 1'b0;
  logic          reset_n = 1'b0, rx_enable = 1'b0, frame_valid = 1'b0, rx_active = 1'b0;
  logic          host_ready = 1'b0, clr_overrun = 1'b0;
  logic [FW-1:0] frame_in = '0;
  logic          sipo_rst_n, host_valid, overrun, timeout_pulse;
  logic [7:0]    host_data;
  logic [2:0]    host_err;
  logic [2:0]    fifo_count;

  int            tests = 0, fails = 0;
  logic [10:0]   q[$];   // {break, framing, parity, data}
  bit            ov = 1'b0;

  always #5 baud_clk = ~baud_clk;

  uart_rx_ctrl dut (
    .baud_clk(baud_clk), .reset_n(reset_n), .rx_enable(rx_enable),
    .frame_in(frame_in), .frame_valid(frame_valid), .rx_active(rx_active),
    .sipo_rst_n(sipo_rst_n), .host_data(host_data), .host_err(host_err),
    .host_valid(host_valid), .host_ready(host_ready), .fifo_count(fifo_count),
    .overrun(overrun), .clr_overrun(clr_overrun), .timeout_pulse(timeout_pulse)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [10:0] model_entry(input logic [10:0] f);
    logic [7:0] d;
    int         ones;
    bit         brk, fr, par;
    d    = f[8:1];
    ones = $countones(d) + int'(f[9]);
    par  = (ones % 2) != 0;          // even parity: data+parity ones must be even
    brk  = (f == 11'd0);
    fr   = brk || f[0] || !f[10];
    return {brk, fr, par, d};
  endfunction

  function automatic logic [10:0] good_frame(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  task automatic step();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    logic [10:0] h;
    h = (q.size() > 0) ? q[0] : 11'd0;
    chk({tag, ".valid"}, 32'(host_valid), 32'(q.size() != 0));
    chk({tag, ".count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, ".data"},  32'(host_data),  32'(h[7:0]));
    chk({tag, ".err"},   32'(host_err),   32'(h[10:8]));
    chk({tag, ".ovr"},   32'(overrun),    32'(ov));
  endtask

  // Frame pulse, then the CHECK edge with optional host pop.
  task automatic send(input logic [10:0] f, input bit pop);
    frame_in = f; frame_valid = 1'b1;
    step();
    frame_valid = 1'b0; host_ready = pop;
    step();
    host_ready = 1'b0;
    if (pop && q.size() > 0) void'(q.pop_front());
    if (q.size() < DEPTH) q.push_back(model_entry(f));
    else ov = 1'b1;
  endtask

  task automatic pop_one(input string tag);
    check_state(tag);
    host_ready = 1'b1;
    step();
    host_ready = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".sipo"},  32'(sipo_rst_n),    32'd0);
    chk({tag, ".data"},  32'(host_data),     32'd0);
    chk({tag, ".err"},   32'(host_err),      32'd0);
    chk({tag, ".valid"}, 32'(host_valid),    32'd0);
    chk({tag, ".count"}, 32'(fifo_count),    32'd0);
    chk({tag, ".ovr"},   32'(overrun),       32'd0);
    chk({tag, ".tmo"},   32'(timeout_pulse), 32'd0);
  endtask

  initial begin
    logic [10:0] f;
    int          r;

    // Reset state and enable
    step(); step();
    chk_reset_vals("rst");
    reset_n = 1'b1;
    step();
    chk("off.sipo", 32'(sipo_rst_n), 32'd0);
    rx_enable = 1'b1;
    step();
    chk("arm.sipo", 32'(sipo_rst_n), 32'd1);

    // Clean frame, two-edge latency, single pop
    send(11'h4B4, 1'b0);
    chk("t1.valid", 32'(host_valid), 32'd1);
    chk("t1.data",  32'(host_data),  32'h5A);
    chk("t1.err",   32'(host_err),   32'd0);
    chk("t1.count", 32'(fifo_count), 32'd1);
    host_ready = 1'b1; step(); host_ready = 1'b0; void'(q.pop_front());
    chk("t1.popcnt", 32'(fifo_count), 32'd0);

    // Error classes
    send(11'h6B4, 1'b0);
    chk("par.data", 32'(host_data), 32'h5A);
    chk("par.err",  32'(host_err),  32'b001);
    pop_one("par");
    send(11'h0B4, 1'b0);
    chk("frm.err", 32'(host_err), 32'b010);
    pop_one("frm");
    send(11'h000, 1'b0);
    chk("brk.data", 32'(host_data), 32'd0);
    chk("brk.err",  32'(host_err),  32'b110);
    pop_one("brk");

    // Overrun: five frames into a 4-deep FIFO
    for (int d = 1; d <= 5; d++) send(good_frame(8'(d)), 1'b0);
    chk("ovr.count", 32'(fifo_count), 32'd4);
    chk("ovr.flag",  32'(overrun),    32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ovr.order", 32'(host_data), 32'(i + 1));
      pop_one("ovr.drain");
    end
    chk("ovr.sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0; ov = 1'b0;
    chk("ovr.clr", 32'(overrun), 32'd0);

    // Full FIFO with a pop during CHECK: push accepted, no overrun
    for (int i = 0; i < 4; i++) send(good_frame(8'($urandom)), 1'b0);
    send(good_frame(8'h77), 1'b1);
    chk("fpop.count", 32'(fifo_count), 32'd4);
    chk("fpop.ovr",   32'(overrun),    32'd0);
    for (int i = 0; i < 3; i++) pop_one("fpop.drain");
    chk("fpop.last", 32'(host_data), 32'h77);
    pop_one("fpop.lastpop");
    check_state("fpop.empty");

    // Randomized traffic against the queue model
    repeat (60) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        f = ($urandom_range(0, 3) == 0) ? 11'($urandom) : good_frame(8'($urandom));
        send(f, 1'($urandom_range(0, 1)));
      end else if (r < 8) begin
        if (q.size() > 0) pop_one("rnd.pop");
        else step();
      end else begin
        clr_overrun = 1'b1; step(); clr_overrun = 1'b0; ov = 1'b0;
      end
      check_state("rnd");
    end
    while (q.size() > 0) pop_one("rnd.drain");
    check_state("rnd.empty");
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0; ov = 1'b0;

    // Timeout resync after TIMEOUT busy cycles
    rx_active = 1'b1;
    repeat (14) step();
    chk("tmo.pre.sipo", 32'(sipo_rst_n),    32'd1);
    chk("tmo.pre.tp",   32'(timeout_pulse), 32'd0);
    step();
    chk("tmo.sipo", 32'(sipo_rst_n),    32'd0);
    chk("tmo.tp",   32'(timeout_pulse), 32'd1);
    rx_active = 1'b0;
    step();
    chk("tmo.post.sipo", 32'(sipo_rst_n),    32'd1);
    chk("tmo.post.tp",   32'(timeout_pulse), 32'd0);

    // Disable mid-frame: in-flight frame dropped, FIFO retained and drainable
    send(good_frame(8'h11), 1'b0);
    send(good_frame(8'h22), 1'b0);
    rx_active = 1'b1;
    step(); step();
    frame_in = good_frame(8'h33); frame_valid = 1'b1; rx_enable = 1'b0;
    step();
    frame_valid = 1'b0; rx_active = 1'b0;
    chk("dis.sipo", 32'(sipo_rst_n), 32'd0);
    check_state("dis.keep");
    step();
    check_state("dis.nopush");
    pop_one("dis.drain");
    check_state("dis.after");
    rx_enable = 1'b1;
    step();
    chk("reen.sipo", 32'(sipo_rst_n), 32'd1);

    // Asynchronous reset with 3 entries queued and overrun set
    while (q.size() < DEPTH) send(good_frame(8'($urandom)), 1'b0);
    send(good_frame(8'hEE), 1'b0);
    pop_one("pre.rst");
    check_state("pre.rst3");
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    q.delete(); ov = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check_state("post.rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
